// File: rtl/vga_tile_fb_arbiter_pkg.sv
// vga_tile_fb_arbiter_pkg: screen geometry, tile map sizes, clear FSM states and tile addressing
package vga_tile_fb_arbiter_pkg;
    localparam int c_VIDEO_WIDTH = 3;
    localparam int c_TOTAL_COLS  = 800;
    localparam int c_TOTAL_ROWS  = 525;
    localparam int c_ACTIVE_COLS = 640;
    localparam int c_ACTIVE_ROWS = 480;
    localparam int c_TILE_SHIFT  = 3;
    localparam int c_TILES_X     = c_ACTIVE_COLS >> c_TILE_SHIFT;
    localparam int c_TILES_Y     = c_ACTIVE_ROWS >> c_TILE_SHIFT;
    localparam int c_NUM_TILES   = c_TILES_X * c_TILES_Y;
    localparam int c_AW          = 13;
    localparam int c_DW          = 3 * c_VIDEO_WIDTH;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    // row*80 built from shifts so the product never truncates below 13 bits
    function automatic logic [c_AW-1:0] tile_addr(input logic [9:0] row, input logic [9:0] col);
        logic [c_AW-1:0] r;
        r = c_AW'(row >> c_TILE_SHIFT);
        return (r << 6) + (r << 4) + c_AW'(col >> c_TILE_SHIFT);
    endfunction
endpackage

// File: rtl/vga_tile_fb_arbiter_if.sv
// vga_tile_fb_arbiter_if: host request/read-back port plus clear control of the tile framebuffer
interface vga_tile_fb_arbiter_if;
    import vga_tile_fb_arbiter_pkg::*;
    logic            i_Host_Valid;
    logic            i_Host_We;
    logic [c_AW-1:0] i_Host_Addr;
    logic [c_DW-1:0] i_Host_Data;
    logic            o_Host_Ready;
    logic            o_Rd_Valid;
    logic [c_DW-1:0] o_Rd_Data;
    logic            i_Clear;
    logic [c_DW-1:0] i_Clear_Color;
    logic            o_Busy;

    modport master (
        output i_Host_Valid, i_Host_We, i_Host_Addr, i_Host_Data, i_Clear, i_Clear_Color,
        input  o_Host_Ready, o_Rd_Valid, o_Rd_Data, o_Busy
    );
    modport slave (
        input  i_Host_Valid, i_Host_We, i_Host_Addr, i_Host_Data, i_Clear, i_Clear_Color,
        output o_Host_Ready, o_Rd_Valid, o_Rd_Data, o_Busy
    );
endinterface

// File: rtl/vga_tile_fb_arbiter_tile_ram.sv
// vga_tile_fb_arbiter_tile_ram: 4800x9 single-port synchronous RAM, read-during-write returns old data
module vga_tile_fb_arbiter_tile_ram
    import vga_tile_fb_arbiter_pkg::*;
(
    input  logic            i_Clk,
    input  logic            we,
    input  logic [c_AW-1:0] addr,
    input  logic [c_DW-1:0] wdata,
    output logic [c_DW-1:0] rdata_q
);
    logic [c_DW-1:0] mem [c_NUM_TILES];

    always_ff @(posedge i_Clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end
endmodule

// File: rtl/vga_tile_fb_arbiter.sv
// vga_tile_fb_arbiter: shares one tile RAM between VGA scanout, a host port and a clear engine
module vga_tile_fb_arbiter
    import vga_tile_fb_arbiter_pkg::*;
(
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic [9:0]               i_Col_Count,
    input  logic [9:0]               i_Row_Count,
    output logic [9:0]               o_Col_Count,
    output logic [9:0]               o_Row_Count,
    output logic [c_VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Blu_Video,
    vga_tile_fb_arbiter_if.slave     host
);
    state_t          state_q, state_d;
    logic [c_AW-1:0] clr_addr_q, clr_addr_d, ram_addr;
    logic [c_DW-1:0] clr_color_q, clr_color_d, color_q, color_d, ram_wdata, ram_rdata;
    logic [9:0]      col_q, col_d, row_q, row_d, nc, nr;
    logic            scan_q, scan_d, rd_valid_q, rd_valid_d, rd_oob_q, rd_oob_d;
    logic            last_col, scan_slot, ready, host_fire, host_oob, clearing, ram_we;

    // the tile under the next pixel is fetched on the last pixel of the current tile
    always_comb begin
        last_col  = i_Col_Count == 10'(c_TOTAL_COLS - 1);
        nc        = last_col ? 10'd0 : i_Col_Count + 10'd1;
        nr        = !last_col ? i_Row_Count
                  : (i_Row_Count == 10'(c_TOTAL_ROWS - 1)) ? 10'd0 : i_Row_Count + 10'd1;
        scan_slot = (i_Col_Count[c_TILE_SHIFT-1:0] == '1) && (nc < 10'(c_ACTIVE_COLS))
                  && (nr < 10'(c_ACTIVE_ROWS));
        ready     = !i_Reset && !scan_slot && state_q == IDLE;
        clearing  = !i_Reset && !scan_slot && state_q == CLEAR;
        host_fire = host.i_Host_Valid && ready;
        host_oob  = host.i_Host_Addr >= c_AW'(c_NUM_TILES);
        ram_addr  = scan_slot ? tile_addr(nr, nc) : clearing ? clr_addr_q
                  : host_oob ? '0 : host.i_Host_Addr;
        ram_we    = clearing || (host_fire && host.i_Host_We && !host_oob);
        ram_wdata = clearing ? clr_color_q : host.i_Host_Data;
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        if (state_q == IDLE && host.i_Clear) begin
            state_d     = CLEAR;
            clr_addr_d  = '0;
            clr_color_d = host.i_Clear_Color;
        end
        if (clearing) begin
            state_d    = (clr_addr_q == c_AW'(c_NUM_TILES - 1)) ? IDLE : CLEAR;
            clr_addr_d = clr_addr_q + c_AW'(1);
        end
        col_d      = i_Col_Count;
        row_d      = i_Row_Count;
        scan_d     = scan_slot;
        rd_valid_d = host_fire && !host.i_Host_We;
        rd_oob_d   = host_oob;
        color_d    = scan_q ? ram_rdata : color_q;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            color_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            scan_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_oob_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
            color_q     <= color_d;
            col_q       <= col_d;
            row_q       <= row_d;
            scan_q      <= scan_d;
            rd_valid_q  <= rd_valid_d;
            rd_oob_q    <= rd_oob_d;
        end
    end

    vga_tile_fb_arbiter_tile_ram u_ram (
        .i_Clk   (i_Clk),
        .we      (ram_we),
        .addr    (ram_addr),
        .wdata   (ram_wdata),
        .rdata_q (ram_rdata)
    );

    assign o_Col_Count       = col_q;
    assign o_Row_Count       = row_q;
    assign {o_Red_Video, o_Grn_Video, o_Blu_Video} =
        (col_q < 10'(c_ACTIVE_COLS) && row_q < 10'(c_ACTIVE_ROWS)) ? color_q : '0;
    assign host.o_Host_Ready = ready;
    assign host.o_Rd_Valid   = rd_valid_q;
    assign host.o_Rd_Data    = (rd_valid_q && !rd_oob_q) ? ram_rdata : '0;
    assign host.o_Busy       = state_q == CLEAR;
endmodule
